// File: rtl/booth8_enc_pipe_pkg.sv
// Shared definitions for the radix-8 Booth encoder and the multiplier stages that consume its flags.
// Holds the digit-group count, the digit-magnitude encoding and the per-group flag typedefs.
package booth8_enc_pipe_pkg;

  localparam int WIDTH_DEFAULT = 8;

  function automatic int group_cnt(input int width);
    return (width >> 2) + 1;
  endfunction

  localparam int GROUP_CNT = group_cnt(WIDTH_DEFAULT);

  typedef enum logic [2:0] {
    MAG_ZERO  = 3'd0,
    MAG_ONE   = 3'd1,
    MAG_TWO   = 3'd2,
    MAG_THREE = 3'd3,
    MAG_FOUR  = 3'd4
  } booth_mag_e;

  typedef struct packed {
    logic s;
    logic d;
    logic t;
    logic q;
    logic n;
  } booth_flags_t;

  typedef logic [GROUP_CNT-1:0] grp_flags_t;

endpackage

// File: rtl/booth8_digit.sv
// Radix-8 Booth digit: maps a 4-bit window {b3,b2,b1,b0} to one-hot magnitude flags plus negate.
// Digit value is -4*b3 + 2*b2 + b1 + b0; zero digits (0000, 1111) produce all-zero flags.
module booth8_digit
  import booth8_enc_pipe_pkg::*;
(
  input  logic [3:0]   win_i,
  output booth_flags_t flags_o
);

  booth_mag_e mag;

  always_comb begin
    mag = MAG_ZERO;
    case (win_i)
      4'b0001, 4'b0010, 4'b1101, 4'b1110: mag = MAG_ONE;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: mag = MAG_TWO;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: mag = MAG_THREE;
      4'b0111, 4'b1000:                   mag = MAG_FOUR;
      default:                            mag = MAG_ZERO;
    endcase

    flags_o   = '0;
    flags_o.s = (mag == MAG_ONE);
    flags_o.d = (mag == MAG_TWO);
    flags_o.t = (mag == MAG_THREE);
    flags_o.q = (mag == MAG_FOUR);
    // A window with b3 set is negative unless it encodes zero.
    flags_o.n = win_i[3] && (mag != MAG_ZERO);
  end

endmodule

// File: rtl/booth8_enc_pipe.sv
// Two-stage valid/ready pipeline: stage A registers the operands, stage B holds the Booth
// flags for mx together with my and 3*my for the downstream partial-product array.
module booth8_enc_pipe
  import booth8_enc_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    mx,
  input  logic [WIDTH-1:0]    my,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(WIDTH>>2):0] s,
  output logic [(WIDTH>>2):0] d,
  output logic [(WIDTH>>2):0] t,
  output logic [(WIDTH>>2):0] q,
  output logic [(WIDTH>>2):0] n,
  output logic [WIDTH-1:0]    my_o,
  output logic [WIDTH+1:0]    tmy_o
);

  localparam int GRP = group_cnt(WIDTH);
  localparam int XW  = 3 * GRP;

  logic                   a_valid_q, a_valid_d;
  logic [WIDTH-1:0]       mx_q, mx_d;
  logic [WIDTH-1:0]       my_q, my_d;
  logic                   b_valid_q, b_valid_d;
  booth_flags_t [GRP-1:0] flags_q, flags_d, flags_c;
  logic [WIDTH-1:0]       myb_q, myb_d;
  logic [WIDTH+1:0]       tmy_q, tmy_d;

  logic             b_load;
  logic             a_adv;
  logic             in_xfer;
  logic [XW:0]      xe;
  logic [WIDTH+1:0] my_ext;

  assign b_load   = !b_valid_q || out_ready;
  assign a_adv    = a_valid_q && b_load;
  assign in_ready = (!a_valid_q || a_adv) && RST;
  assign in_xfer  = in_valid && in_ready;

  // Bit 0 is the implicit x[-1]=0, so window i sits at xe[3i+3:3i].
  assign xe     = {{(XW - WIDTH){mx_q[WIDTH-1]}}, mx_q, 1'b0};
  assign my_ext = {{2{my_q[WIDTH-1]}}, my_q};

  genvar gi;
  generate
    for (gi = 0; gi < GRP; gi++) begin : g_digit
      booth8_digit u_digit (
        .win_i   (xe[3*gi+3 -: 4]),
        .flags_o (flags_c[gi])
      );
      assign s[gi] = flags_q[gi].s;
      assign d[gi] = flags_q[gi].d;
      assign t[gi] = flags_q[gi].t;
      assign q[gi] = flags_q[gi].q;
      assign n[gi] = flags_q[gi].n;
    end
  endgenerate

  always_comb begin
    a_valid_d = a_valid_q;
    mx_d      = mx_q;
    my_d      = my_q;
    b_valid_d = b_valid_q;
    flags_d   = flags_q;
    myb_d     = myb_q;
    tmy_d     = tmy_q;

    if (in_ready) a_valid_d = in_valid;
    if (in_xfer) begin
      mx_d = mx;
      my_d = my;
    end

    if (b_load) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        flags_d = flags_c;
        myb_d   = my_q;
        tmy_d   = (my_ext << 1) + my_ext;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      a_valid_q <= 1'b0;
      mx_q      <= '0;
      my_q      <= '0;
      b_valid_q <= 1'b0;
      flags_q   <= '0;
      myb_q     <= '0;
      tmy_q     <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      b_valid_q <= b_valid_d;
      flags_q   <= flags_d;
      myb_q     <= myb_d;
      tmy_q     <= tmy_d;
    end
  end

  assign out_valid = b_valid_q;
  assign my_o      = myb_q;
  assign tmy_o     = tmy_q;

endmodule

// File: tb/tb_booth8_enc_pipe.sv
// Bench for booth8_enc_pipe (WIDTH=8): directed vector table, stall/backpressure sequence,
// mid-flight reset, and a full mx sweep checked by reconstructing the Booth digit sum.
module tb_booth8_enc_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mx;
  logic [7:0] my;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] s, d, t, q, n;
  logic [7:0] my_o;
  logic [9:0] tmy_o;

  booth8_enc_pipe #(.WIDTH(8)) dut (
    .CLK       (clk),
    .RST       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mx        (mx),
    .my        (my),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .d         (d),
    .t         (t),
    .q         (q),
    .n         (n),
    .my_o      (my_o),
    .tmy_o     (tmy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mx;
    logic [7:0] my;
    logic [2:0] s, d, t, q, n;
    logic [9:0] tmy;
  } vec_t;

  typedef struct {
    logic [7:0] mx;
    logic [7:0] my;
  } op_t;

  int  n_chk;
  int  n_fail;
  int  got;
  bit  mon_en;
  op_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // Rebuild sum(D_i * 8^i) from the flags and compare with the signed operand.
  task automatic check_out(input op_t op);
    int   sum;
    int   mag;
    int   cnt;
    int   mxv;
    int   myv;
    logic bad;
    sum = 0;
    bad = 1'b0;
    for (int g = 0; g < 3; g++) begin
      cnt = int'(s[g]) + int'(d[g]) + int'(t[g]) + int'(q[g]);
      mag = s[g] ? 1 : d[g] ? 2 : t[g] ? 3 : q[g] ? 4 : 0;
      if (cnt > 1 || (n[g] && mag == 0)) bad = 1'b1;
      sum += (n[g] ? -mag : mag) * (1 << (3 * g));
    end
    mxv = $signed(op.mx);
    myv = $signed(op.my);
    $display("xfer mx=%h my=%h s=%b d=%b t=%b q=%b n=%b my_o=%h tmy=%h",
             op.mx, op.my, s, d, t, q, n, my_o, tmy_o);
    chk("digit_sum", sum, mxv);
    chk("flags_legal", {31'b0, bad}, 32'd0);
    chk("my_o", {24'b0, my_o}, {24'b0, op.my});
    chk("tmy_o", {22'b0, tmy_o}, {22'b0, 10'(myv * 3)});
  endtask

  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: actual my_o=%h required none", my_o);
        end else begin
          check_out(exp_q.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{mx, my});
    end
  end

  vec_t       vecs[8];
  logic [7:0] st_mx[5] = '{8'h11, 8'hE7, 8'h5C, 8'h80, 8'h3B};
  logic [7:0] st_my[5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

  initial begin
    int lat;
    int idx;
    vecs[0] = '{8'h07, 8'h05, 3'b011, 3'b000, 3'b000, 3'b000, 3'b001, 10'h00F};
    vecs[1] = '{8'h80, 8'h80, 3'b000, 3'b100, 3'b000, 3'b000, 3'b100, 10'h280};
    vecs[2] = '{8'h04, 8'h01, 3'b010, 3'b000, 3'b000, 3'b001, 3'b001, 10'h003};
    vecs[3] = '{8'h03, 8'hC0, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 10'h340};
    vecs[4] = '{8'hFF, 8'hFF, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 10'h3FD};
    vecs[5] = '{8'h7F, 8'h7F, 3'b001, 3'b100, 3'b000, 3'b000, 3'b001, 10'h17D};
    vecs[6] = '{8'h00, 8'h00, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 10'h000};
    vecs[7] = '{8'h24, 8'h9C, 3'b100, 3'b000, 3'b010, 3'b001, 3'b011, 10'h2D4};

    n_chk     = 0;
    n_fail    = 0;
    got       = 0;
    mon_en    = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mx        = 8'h00;
    my        = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_flags", {17'b0, s, d, t, q, n}, 32'd0);
    chk("rst_my_o", {24'b0, my_o}, 32'd0);
    chk("rst_tmy_o", {22'b0, tmy_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed vector table, one operand at a time
    for (int v = 0; v < 8; v++) begin
      @(posedge clk);
      #1;
      mx       = vecs[v].mx;
      my       = vecs[v].my;
      in_valid = 1'b1;
      @(negedge clk);
      chk("vec_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      for (int w = 0; w < 10; w++) begin
        @(negedge clk);
        lat++;
        if (out_valid) break;
      end
      $display("vec %0d mx=%h my=%h s=%b d=%b t=%b q=%b n=%b my_o=%h tmy=%h lat=%0d",
               v, vecs[v].mx, vecs[v].my, s, d, t, q, n, my_o, tmy_o, lat);
      chk("vec_latency", lat, 2);
      chk("vec_out_valid", {31'b0, out_valid}, 32'd1);
      chk("vec_flags", {17'b0, s, d, t, q, n},
          {17'b0, vecs[v].s, vecs[v].d, vecs[v].t, vecs[v].q, vecs[v].n});
      chk("vec_my_o", {24'b0, my_o}, {24'b0, vecs[v].my});
      chk("vec_tmy_o", {22'b0, tmy_o}, {22'b0, vecs[v].tmy});
    end
    @(posedge clk);

    // Back-to-back stream with out_ready low in cycles 3-5
    exp_q.delete();
    got    = 0;
    mon_en = 1'b1;
    idx    = 0;
    for (int c = 1; c <= 30 && got < 5; c++) begin
      @(posedge clk);
      #1;
      in_valid  = (idx < 5);
      mx        = (idx < 5) ? st_mx[idx] : 8'h00;
      my        = (idx < 5) ? st_my[idx] : 8'h00;
      out_ready = (c < 3 || c > 5);
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_my_o", {24'b0, my_o}, {24'b0, st_my[0]});
        chk("stall_tmy_o", {22'b0, tmy_o}, {22'b0, 10'(int'($signed(st_my[0])) * 3)});
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stall_delivered", got, 5);
    chk("stall_queue_empty", exp_q.size(), 0);
    mon_en = 1'b0;

    // Reset pulsed with two operands in flight
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mx        = 8'h11;
    my        = 8'h22;
    @(posedge clk);
    #1;
    mx = 8'h33;
    my = 8'h44;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    chk("midrst_pre_valid", {31'b0, out_valid}, 32'd1);
    chk("midrst_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_flags", {17'b0, s, d, t, q, n}, 32'd0);
    chk("midrst_my_o", {24'b0, my_o}, 32'd0);
    chk("midrst_tmy_o", {22'b0, tmy_o}, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_no_output", {31'b0, out_valid}, 32'd0);
    end

    // Full sweep of mx, streamed at one operand per cycle
    exp_q.delete();
    got    = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      mx       = 8'(i);
      my       = 8'(i) ^ 8'h5A;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int w = 0; w < 20 && got < 256; w++) @(posedge clk);
    @(negedge clk);
    chk("sweep_delivered", got, 256);
    chk("sweep_queue_empty", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/booth8_enc_pipe.md
BOOTH8_ENC_PIPE -- requirements
Module: booth8_enc_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width; the only legal values are 4 and 8.
REQ-002 Constant GROUP_CNT = (WIDTH>>2)+1, the number of radix-8 Booth digit groups (3 for WIDTH=8).
REQ-003 CLK  input  1  the only clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operand pair mx/my is presented.
REQ-006 in_ready  output  1  the block accepts the operands this cycle.
REQ-007 mx  input  WIDTH  signed multiplier to be Booth-encoded.
REQ-008 my  input  WIDTH  signed multiplicand.
REQ-009 out_valid  output  1  the encoded set on s..tmy is valid.
REQ-010 out_ready  input  1  the downstream multiplier-array stage consumes this cycle.
REQ-011 s, d, t, q, n  output  GROUP_CNT each  per-group flags: magnitude 1, 2, 3 or 4, and negate.
REQ-012 my_o  output  WIDTH  registered multiplicand.
REQ-013 tmy_o  output  WIDTH+2  registered 3*my, signed.

Function
REQ-014 A transfer in SHALL occur when in_valid and in_ready are both high; a transfer out SHALL occur when out_valid and out_ready are both high.
REQ-015 The pipeline SHALL have two register stages: stage A captures mx and my, and stage B holds the encoded flags, my_o and tmy_o.
REQ-016 The latency SHALL be 2 cycles from the input transfer to out_valid, with a throughput of 1 per cycle while out_ready is high.
REQ-017 Stage B SHALL load when it is empty or being consumed, and stage A SHALL advance into stage B under the same condition.
REQ-018 in_ready SHALL equal (!A_valid | A_advances) & RST, and SHALL be combinational with no dependence on in_valid.
REQ-019 While out_valid is high and out_ready is low, all outputs SHALL hold stable, and stage A SHALL hold once it is full.
REQ-020 Group i SHALL use the window x[3i+2:3i-1], with x[-1]=0 and mx sign-extended to 3*GROUP_CNT bits.
REQ-021 Each group digit SHALL be D = -4*b3 + 2*b2 + b1 + b0, with range -4..+4.
REQ-022 Exactly one of s/d/t/q SHALL be set, for |D| = 1/2/3/4 respectively.
REQ-023 n SHALL be set when D < 0.
REQ-024 For D = 0, all five flags of the group SHALL be 0; this covers windows 0000 and 1111, and n=0 in both cases.
REQ-025 tmy_o SHALL equal sign-extended my*3 to WIDTH+2 bits, computed as (my<<1)+my with no truncation.
REQ-026 my_o SHALL be my passed through unchanged, aligned with its flags.
REQ-027 A simultaneous output transfer and input transfer with the pipeline full SHALL lose no data and SHALL stall no cycle.

Reset
REQ-028 While RST is 0 at a clock edge, the A and B valid bits SHALL clear and all data registers SHALL clear to 0.
REQ-029 Outputs after reset SHALL be out_valid=0, s=d=t=q=n=0, my_o=0 and tmy_o=0.
REQ-030 in_ready SHALL be 0 while RST is low, and SHALL be 1 in the first cycle after release.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operands with no partial output.

Structure
REQ-032 The shared package SHALL hold GROUP_CNT, the digit-magnitude encoding, and the flag-vector typedef; the downstream multiplier stages reuse these.
REQ-033 One combinational sub-module, booth8_digit, SHALL map a 4-bit window to {s,d,t,q,n}, instantiated GROUP_CNT times.

Verification
REQ-034 mx=8'h07, my=8'h05, out_ready=1 -> after 2 cycles: s=3'b011, n=3'b001, d=t=q=0, my_o=8'h05, tmy_o=10'h00F.
REQ-035 mx=8'h80, my=8'h80 -> d=3'b100, n=3'b100, s=t=q=0, tmy_o=10'h280.
REQ-036 mx=8'h04 gives q=3'b001, n=3'b001, s=3'b010; and mx=8'h03 gives t=3'b001 with all other flags 0.
REQ-037 Back-to-back stream of 5 operands with out_ready low for cycles 3-5 -> pipeline fills, in_ready=0 while both stages are full, outputs stable, then all 5 results delivered in order with none lost or duplicated.
REQ-038 RST=0 pulsed while 2 operands are in flight -> next cycle out_valid=0 and all outputs 0, and in_ready=1 after release.
REQ-039 Exhaustive sweep of all 256 mx values -> the sum over i of D_i*8^i equals mx, and no group has more than one magnitude flag set.
